systolic_mm_engine: RTL and testbench

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

---
 rtl/systolic_mm_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - ROWS x COLS output-stationary systolic matrix-multiply engine
//
// Computes C[i][j] = sum_k A[k][i] * B[k][j] for a job of depth k_len. The job
// runs through the states IDLE -> LOAD -> COMPUTE -> DRAIN -> DONE -> IDLE.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   start, k_len           job request and reduction depth (both sampled in IDLE)
//   a_valid/a_ready/a_data activation columns in; lane i = bits [i*DW +: DW]
//   b_valid/b_ready/b_data weight rows in; lane j = bits [j*DW +: DW]
//   res_valid/res_ready    result rows out; res_data column j = bits [j*ACC_W +: ACC_W]
//   res_row_idx            row index of res_data
//   busy                   high whenever the engine is not idle
//   compute_done           one-cycle pulse in DONE
//   err_klen               one-cycle pulse after a start with an illegal k_len
//   cycles_count           saturating cycle count of the last or current job
module systolic_mm_engine #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int K_MAX = 16,
    localparam int KW   = $clog2(K_MAX + 1),
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ROWS*DW-1:0]    a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [COLS*DW-1:0]    b_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [COLS*ACC_W-1:0] res_data,
    output logic [RW-1:0]         res_row_idx,
    output logic                  busy,
    output logic                  compute_done,
    output logic                  err_klen,
    output logic [15:0]           cycles_count
);

    localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int TW = $clog2(K_MAX + ROWS + COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    a_cnt_q;
    logic [KW-1:0]    b_cnt_q;
    logic [TW-1:0]    t_q;
    logic [RW-1:0]    r_q;
    logic [15:0]      cyc_q;
    logic             err_q;

    logic signed [DW-1:0]    a_buf    [K_MAX][ROWS];
    logic signed [DW-1:0]    b_buf    [K_MAX][COLS];
    logic signed [DW-1:0]    a_pipe_q [ROWS][COLS];
    logic signed [DW-1:0]    b_pipe_q [ROWS][COLS];
    logic signed [ACC_W-1:0] acc_q    [ROWS][COLS];

    logic signed [DW-1:0]    a_edge   [ROWS];
    logic signed [DW-1:0]    b_edge   [COLS];
    logic signed [DW-1:0]    a_in     [ROWS][COLS];
    logic signed [DW-1:0]    b_in     [ROWS][COLS];
    logic signed [ACC_W-1:0] prod_ext [ROWS][COLS];

    logic          a_fire;
    logic          b_fire;
    logic          res_fire;
    logic          start_ok;
    logic          last_step;
    logic [TW-1:0] a_idx;
    logic [TW-1:0] b_idx;

    assign a_ready      = (state_q == S_LOAD) && (a_cnt_q < k_q);
    assign b_ready      = (state_q == S_LOAD) && (b_cnt_q < k_q);
    assign a_fire       = a_valid && a_ready;
    assign b_fire       = b_valid && b_ready;
    assign res_valid    = (state_q == S_DRAIN);
    assign res_fire     = res_valid && res_ready;
    assign res_row_idx  = r_q;
    assign busy         = (state_q != S_IDLE);
    assign compute_done = (state_q == S_DONE);
    assign err_klen     = err_q;
    assign cycles_count = cyc_q;

    assign start_ok  = start && (k_len != '0) && (k_len <= KW'(K_MAX));
    // Last step is when the final (k, row, col) wavefront reaches PE(ROWS-1, COLS-1).
    assign last_step = (t_q == TW'(k_q) + TW'(ROWS + COLS - 3));

    // Skewed edge feed: row i (column j) lags by i (j) steps, zero outside the job depth.
    always_comb begin
        a_idx = '0;
        b_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            a_edge[i] = '0;
            a_idx     = t_q - TW'(i);
            if ((t_q >= TW'(i)) && (a_idx < TW'(k_q)))
                a_edge[i] = a_buf[a_idx[AW-1:0]][i];
        end
        for (int j = 0; j < COLS; j++) begin
            b_edge[j] = '0;
            b_idx     = t_q - TW'(j);
            if ((t_q >= TW'(j)) && (b_idx < TW'(k_q)))
                b_edge[j] = b_buf[b_idx[AW-1:0]][j];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic signed [2*DW-1:0] prod;
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = a_edge[gi];
            end else begin : g_a_pipe
                assign a_in[gi][gj] = a_pipe_q[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = b_edge[gj];
            end else begin : g_b_pipe
                assign b_in[gi][gj] = b_pipe_q[gi-1][gj];
            end
            assign prod           = a_in[gi][gj] * b_in[gi][gj];
            assign prod_ext[gi][gj] = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
        end
    end

    always_comb begin
        res_data = '0;
        for (int j = 0; j < COLS; j++)
            res_data[j*ACC_W +: ACC_W] = acc_q[r_q][j];
    end

    // Operand buffers carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (a_fire)
            for (int i = 0; i < ROWS; i++)
                a_buf[a_cnt_q[AW-1:0]][i] <= a_data[i*DW +: DW];
        if (b_fire)
            for (int j = 0; j < COLS; j++)
                b_buf[b_cnt_q[AW-1:0]][j] <= b_data[j*DW +: DW];
    end

    // PE array: operands move right/down one PE per cycle, accumulators stay put.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_pipe_q[i][j] <= '0;
                    b_pipe_q[i][j] <= '0;
                    acc_q[i][j]    <= '0;
                end
        end else if ((state_q == S_IDLE) && start_ok) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_pipe_q[i][j] <= '0;
                    b_pipe_q[i][j] <= '0;
                    acc_q[i][j]    <= '0;
                end
        end else if (state_q == S_COMPUTE) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_pipe_q[i][j] <= a_in[i][j];
                    b_pipe_q[i][j] <= b_in[i][j];
                    acc_q[i][j]    <= acc_q[i][j] + prod_ext[i][j];
                end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            t_q     <= '0;
            r_q     <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if ((state_q != S_IDLE) && (cyc_q != 16'hFFFF))
                cyc_q <= cyc_q + 16'd1;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        k_q     <= k_len;
                        a_cnt_q <= '0;
                        b_cnt_q <= '0;
                        t_q     <= '0;
                        r_q     <= '0;
                        cyc_q   <= '0;
                        state_q <= S_LOAD;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (a_fire) a_cnt_q <= a_cnt_q + KW'(1);
                    if (b_fire) b_cnt_q <= b_cnt_q + KW'(1);
                    if ((a_cnt_q == k_q) && (b_cnt_q == k_q))
                        state_q <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (last_step) begin
                        t_q     <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (res_fire) begin
                        if (r_q == RW'(ROWS - 1)) begin
                            r_q     <= '0;
                            state_q <= S_DONE;
                        end else begin
                            r_q <= r_q + RW'(1);
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - directed self-checking bench for systolic_mm_engine
module tb_systolic_mm_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  k_len = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [31:0] b_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [95:0] res_data;
    logic [1:0]  res_row_idx;
    logic        busy;
    logic        compute_done;
    logic        err_klen;
    logic [15:0] cycles_count;

    int passed = 0;
    int total  = 0;

    logic signed [7:0] am [16][4];
    logic signed [7:0] bm [16][4];
    int                exp_v [4][4];
    logic [95:0]       got_rows [4];
    int                got_idx [4];
    logic              got_done;
    int                got_cyc;
    bit                got_timeout;

    systolic_mm_engine dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row_idx(res_row_idx), .busy(busy), .compute_done(compute_done),
        .err_klen(err_klen), .cycles_count(cycles_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k);
        k_len = 5'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_a(input int n);
        for (int i = 0; i < 4; i++) a_data[i*8 +: 8] = am[n][i];
    endtask

    task automatic set_b(input int n);
        for (int j = 0; j < 4; j++) b_data[j*8 +: 8] = bm[n][j];
    endtask

    // Both channels beat together from the first LOAD cycle, no gaps.
    task automatic load_both(input int k);
        for (int n = 0; n < k; n++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            set_a(n); set_b(n);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // Drains all four rows with res_ready held high, then samples the DONE and IDLE cycles.
    task automatic drain_rows();
        int n;
        got_timeout = 1'b0;
        res_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (!res_valid && n < 200) begin
                tick();
                n++;
            end
            if (!res_valid) got_timeout = 1'b1;
            got_rows[r] = res_data;
            got_idx[r]  = int'(res_row_idx);
            tick();
        end
        got_done = compute_done;
        res_ready = 1'b0;
        tick();
        got_cyc = int'(cycles_count);
    endtask

    task automatic check_results(input string name);
        total++;
        if (got_timeout) $display("FAIL %s timeout: res_valid never seen within 200 cycles", name);
        else passed++;
        for (int r = 0; r < 4; r++) begin
            total++;
            if (got_idx[r] !== r) $display("FAIL %s row_idx[%0d]: got %0d want %0d", name, r, got_idx[r], r);
            else passed++;
            for (int c = 0; c < 4; c++) begin
                total++;
                if ($signed(got_rows[r][c*24 +: 24]) !== exp_v[r][c])
                    $display("FAIL %s C[%0d][%0d]: got %0d want %0d", name, r, c,
                             $signed(got_rows[r][c*24 +: 24]), exp_v[r][c]);
                else passed++;
            end
        end
    endtask

    task automatic setup_identity();
        for (int k = 0; k < 4; k++)
            for (int x = 0; x < 4; x++) begin
                am[k][x] = (k == x) ? 8'sd1 : 8'sd0;
                bm[k][x] = 8'(4*k + x + 1);
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) exp_v[r][c] = 4*r + c + 1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
        total++; if (a_ready !== 1'b0) $display("FAIL reset a_ready: got %b want 0", a_ready); else passed++;
        total++; if (b_ready !== 1'b0) $display("FAIL reset b_ready: got %b want 0", b_ready); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL reset res_valid: got %b want 0", res_valid); else passed++;
        total++; if (compute_done !== 1'b0) $display("FAIL reset compute_done: got %b want 0", compute_done); else passed++;
        total++; if (err_klen !== 1'b0) $display("FAIL reset err_klen: got %b want 0", err_klen); else passed++;
        total++; if (cycles_count !== 16'd0) $display("FAIL reset cycles_count: got %0d want 0", cycles_count); else passed++;
        total++; if (res_data !== 96'd0) $display("FAIL reset res_data: got %h want 0", res_data); else passed++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        setup_identity();
        start_job(4);
        total++; if (busy !== 1'b1) $display("FAIL identity busy: got %b want 1", busy); else passed++;
        load_both(4);
        drain_rows();
        check_results("identity");
        total++; if (got_done !== 1'b1) $display("FAIL identity compute_done after row3: got %b want 1", got_done); else passed++;
        // 4 loads + 1 + (4+4+4-2) + 4 + 1
        total++; if (got_cyc !== 20) $display("FAIL identity cycles_count: got %0d want 20", got_cyc); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL identity busy after done: got %b want 0", busy); else passed++;
    endtask

    task automatic test_signed();
        for (int x = 0; x < 4; x++) begin am[0][x] = -8'sd128; bm[0][x] = -8'sd128; end
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp_v[r][c] = 16384;
        start_job(1);
        load_both(1);
        drain_rows();
        check_results("signed_min");
        for (int k = 0; k < 16; k++)
            for (int x = 0; x < 4; x++) begin am[k][x] = 8'sd127; bm[k][x] = 8'sd127; end
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp_v[r][c] = 258064;
        start_job(16);
        load_both(16);
        drain_rows();
        check_results("signed_max_k16");
        // 16 + 1 + 22 + 4 + 1
        total++; if (got_cyc !== 44) $display("FAIL k16 cycles_count: got %0d want 44", got_cyc); else passed++;
    endtask

    task automatic test_bad_len();
        k_len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (err_klen !== 1'b1) $display("FAIL badlen k0 err_klen: got %b want 1", err_klen); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL badlen k0 busy: got %b want 0", busy); else passed++;
        total++; if (a_ready !== 1'b0) $display("FAIL badlen k0 a_ready: got %b want 0", a_ready); else passed++;
        tick();
        total++; if (err_klen !== 1'b0) $display("FAIL badlen k0 pulse width: got %b want 0", err_klen); else passed++;
        k_len = 5'd17; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (err_klen !== 1'b1) $display("FAIL badlen k17 err_klen: got %b want 1", err_klen); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL badlen k17 busy: got %b want 0", busy); else passed++;
        total++; if (a_ready !== 1'b0) $display("FAIL badlen k17 a_ready: got %b want 0", a_ready); else passed++;
        tick();
        total++; if (err_klen !== 1'b0) $display("FAIL badlen k17 pulse width: got %b want 0", err_klen); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL badlen final busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        // A all ones, B[k][j] = j+1, k=3 -> every row is {3,6,9,12}
        for (int k = 0; k < 3; k++)
            for (int x = 0; x < 4; x++) begin am[k][x] = 8'sd1; bm[k][x] = 8'(x + 1); end
        start_job(3);
        load_both(3);
        res_ready = 1'b1;
        n = 0;
        while (!res_valid && n < 200) begin tick(); n++; end
        total++; if (res_valid !== 1'b1) $display("FAIL bp timeout: res_valid got %b want 1", res_valid); else passed++;
        tick();
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            total++; if (res_row_idx !== 2'd1) $display("FAIL bp stall%0d row_idx: got %0d want 1", s, res_row_idx); else passed++;
            for (int c = 0; c < 4; c++) begin
                total++;
                if ($signed(res_data[c*24 +: 24]) !== 3*(c + 1))
                    $display("FAIL bp stall%0d col%0d: got %0d want %0d", s, c, $signed(res_data[c*24 +: 24]), 3*(c + 1));
                else passed++;
            end
            tick();
        end
        res_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            total++; if (res_row_idx !== 2'(r)) $display("FAIL bp row_idx: got %0d want %0d", res_row_idx, r); else passed++;
            total++;
            if ($signed(res_data[3*24 +: 24]) !== 12)
                $display("FAIL bp row%0d col3: got %0d want 12", r, $signed(res_data[3*24 +: 24]));
            else passed++;
            tick();
        end
        res_ready = 1'b0;
        total++; if (compute_done !== 1'b1) $display("FAIL bp compute_done: got %b want 1", compute_done); else passed++;
        tick();
        // 3 + 1 + 9 + (4 + 5 stall) + 1
        total++; if (cycles_count !== 16'd23) $display("FAIL bp cycles_count: got %0d want 23", cycles_count); else passed++;
    endtask

    task automatic test_skewed();
        // k=2: A cols {1,2,3,4},{-1,0,1,2}; B rows {1,2,3,4},{10,10,10,10}
        am[0][0] = 1;  am[0][1] = 2; am[0][2] = 3; am[0][3] = 4;
        am[1][0] = -1; am[1][1] = 0; am[1][2] = 1; am[1][3] = 2;
        bm[0][0] = 1;  bm[0][1] = 2; bm[0][2] = 3; bm[0][3] = 4;
        for (int x = 0; x < 4; x++) bm[1][x] = 10;
        exp_v[0] = '{-9, -8, -7, -6};
        exp_v[1] = '{2, 4, 6, 8};
        exp_v[2] = '{13, 16, 19, 22};
        exp_v[3] = '{24, 28, 32, 36};
        start_job(2);
        total++; if (a_ready !== 1'b1) $display("FAIL skew a_ready initial: got %b want 1", a_ready); else passed++;
        for (int n = 0; n < 2; n++) begin
            a_valid = 1'b1; set_a(n);
            tick();
        end
        a_valid = 1'b0;
        total++; if (a_ready !== 1'b0) $display("FAIL skew a_ready after k beats: got %b want 0", a_ready); else passed++;
        total++; if (b_ready !== 1'b1) $display("FAIL skew b_ready waiting: got %b want 1", b_ready); else passed++;
        for (int n = 0; n < 2; n++) begin
            b_valid = 1'b1; set_b(n);
            tick();
        end
        b_valid = 1'b0;
        drain_rows();
        check_results("skewed");
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        setup_identity();
        start_job(4);
        load_both(4);
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL abort busy: got %b want 0", busy); else passed++;
        total++; if (res_valid !== 1'b0) $display("FAIL abort res_valid: got %b want 0", res_valid); else passed++;
        total++; if (cycles_count !== 16'd0) $display("FAIL abort cycles_count: got %0d want 0", cycles_count); else passed++;
        total++; if (res_data !== 96'd0) $display("FAIL abort res_data: got %h want 0", res_data); else passed++;
        seen_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (compute_done) seen_done = 1'b1;
        end
        reset = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (compute_done) seen_done = 1'b1;
            if (n < 19) tick();
        end
        total++; if (seen_done !== 1'b0) $display("FAIL abort compute_done seen: got %b want 0", seen_done); else passed++;
        start_job(4);
        total++; if (busy !== 1'b1) $display("FAIL abort restart busy: got %b want 1", busy); else passed++;
        load_both(4);
        drain_rows();
        check_results("after_abort");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_bad_len();
        test_backpressure();
        test_skewed();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
